// File: rtl/aes_shift_rows_pipe_if.sv
// Handshake bundle for aes_shift_rows_pipe: input-side state offer, output-side
// buffered head, flush, and status counters.
interface aes_shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int DEPTH = 2
);
  localparam int W  = 32 * NB;
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          inv_i;
  logic [W-1:0]  state_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  state_o;
  logic          inv_o;
  logic [CW-1:0] count_o;
  logic [15:0]   done_cnt_o;

  // slave = the ShiftRows block, master = whoever feeds and drains it
  modport slave (
    input  flush_i, in_valid_i, inv_i, state_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o, inv_o, count_o, done_cnt_o
  );

  modport master (
    output flush_i, in_valid_i, inv_i, state_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o, inv_o, count_o, done_cnt_o
  );
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// Rijndael (Inv)ShiftRows applied combinationally on the input, with the result
// buffered in a small DEPTH-entry FIFO that counts completed output transfers.
module aes_shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  aes_shift_rows_pipe_if.slave bus
);
  localparam int W  = 32 * NB;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("aes_shift_rows_pipe: DEPTH must be in 1..8");
  end

  // Rijndael row offsets: wide (8-column) blocks skip offset 2.
  function automatic int row_off(input int r);
    if (NB == 8) return (r >= 2) ? r + 1 : r;
    else         return r;
  endfunction

  // Column 0 occupies the most significant word, row 0 the top byte of it.
  function automatic int byte_hi(input int c, input int r);
    return W - 1 - 32 * c - 8 * r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic [W-1:0] w_fwd;
  logic [W-1:0] w_inv;
  logic [W-1:0] w_shifted;

  // Pure byte permutation: every output byte is wired from exactly one input byte.
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < NB; gc++) begin : g_col
      localparam int SRC    = (gc + row_off(gr)) % NB;
      localparam int HI_DST = byte_hi(gc, gr);
      localparam int HI_SRC = byte_hi(SRC, gr);
      assign w_fwd[HI_DST -: 8] = bus.state_i[HI_SRC -: 8];
      assign w_inv[HI_SRC -: 8] = bus.state_i[HI_DST -: 8];
    end
  end

  assign w_shifted = bus.inv_i ? w_inv : w_fwd;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both
  // high; ready never depends on valid, and flush cancels every transfer that cycle.
  logic [W-1:0]    r_mem_state [DEPTH];
  logic [DEPTH-1:0] r_mem_inv;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_done_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  assign w_in_ready  = rst_n & (r_count < DEPTH_C) & ~bus.flush_i;
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid_i & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready_i & ~bus.flush_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_done_cnt <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr   <= ptr_inc(r_rd_ptr);
        r_done_cnt <= r_done_cnt + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the count is zero.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_state[r_wr_ptr] <= w_shifted;
      r_mem_inv[r_wr_ptr]   <= bus.inv_i;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.state_o     = w_out_valid ? r_mem_state[r_rd_ptr] : '0;
  assign bus.inv_o       = w_out_valid & r_mem_inv[r_rd_ptr];
  assign bus.count_o     = r_count;
  assign bus.done_cnt_o  = r_done_cnt;
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: an NB=4/DEPTH=2 and an NB=8/DEPTH=3 instance,
// each tracked by an independent byte-level model and an expected-result queue.
module tb_aes_shift_rows_pipe;
  logic clk_i = 1'b0;
  logic rst_n;
  always #5 clk_i = ~clk_i;

  aes_shift_rows_pipe_if #(.NB(4), .DEPTH(2)) if4 ();
  aes_shift_rows_pipe_if #(.NB(8), .DEPTH(3)) if8 ();

  aes_shift_rows_pipe #(.NB(4), .DEPTH(2)) dut4 (.clk_i(clk_i), .rst_n(rst_n), .bus(if4));
  aes_shift_rows_pipe #(.NB(8), .DEPTH(3)) dut8 (.clk_i(clk_i), .rst_n(rst_n), .bus(if8));

  int n_tests = 0;
  int n_fail  = 0;

  logic [128:0] exp_q4[$];
  logic [256:0] exp_q8[$];
  logic [15:0]  done4 = 16'd0;
  logic [15:0]  done8 = 16'd0;

  localparam logic [127:0] V_PLAIN = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V_SHIFT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  function automatic logic [255:0] ref_shift(input int nb, input logic inv, input logic [255:0] s);
    logic [7:0] b [4][8];
    logic [7:0] o [4][8];
    int off [4];
    int w;
    int d;
    logic [255:0] res;
    w = 32 * nb;
    for (int r = 0; r < 4; r++) off[r] = (nb == 8 && r >= 2) ? r + 1 : r;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        b[r][c] = 8'h00;
        o[r][c] = 8'h00;
      end
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) b[r][c] = s[w-1-32*c-8*r -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        d = (c + off[r]) % nb;
        if (!inv) o[r][c] = b[r][d];
        else      o[r][d] = b[r][c];
      end
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) res[w-1-32*c-8*r -: 8] = o[r][c];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard for the NB=4 instance, evaluated mid-cycle when inputs are settled.
  always @(negedge clk_i) begin : mon4
    int sz;
    logic [255:0] t;
    if (rst_n) begin
      sz = exp_q4.size();
      n_tests++;
      if (if4.count_o !== 2'(sz)) begin
        n_fail++; $display("FAIL mon4_count: got %0d want %0d", if4.count_o, sz);
      end
      n_tests++;
      if (if4.out_valid_o !== (sz != 0)) begin
        n_fail++; $display("FAIL mon4_out_valid: got %b want %b", if4.out_valid_o, sz != 0);
      end
      n_tests++;
      if (if4.in_ready_o !== ((sz < 2) && !if4.flush_i)) begin
        n_fail++; $display("FAIL mon4_in_ready: got %b want %b", if4.in_ready_o, (sz < 2) && !if4.flush_i);
      end
      n_tests++;
      if (sz > 0) begin
        if ({if4.inv_o, if4.state_o} !== exp_q4[0]) begin
          n_fail++; $display("FAIL mon4_head: got %h want %h", {if4.inv_o, if4.state_o}, exp_q4[0]);
        end
      end else if ({if4.inv_o, if4.state_o} !== 129'd0) begin
        n_fail++; $display("FAIL mon4_idle_zero: got %h want 0", {if4.inv_o, if4.state_o});
      end
      n_tests++;
      if (if4.done_cnt_o !== done4) begin
        n_fail++; $display("FAIL mon4_done_cnt: got %h want %h", if4.done_cnt_o, done4);
      end
      if (if4.flush_i) exp_q4.delete();
      else begin
        if (sz > 0 && if4.out_ready_i) begin
          void'(exp_q4.pop_front());
          done4 = done4 + 16'd1;
        end
        if (if4.in_valid_i && sz < 2) begin
          t = ref_shift(4, if4.inv_i, {128'd0, if4.state_i});
          exp_q4.push_back({if4.inv_i, t[127:0]});
        end
      end
    end
  end

  always @(negedge clk_i) begin : mon8
    int sz;
    logic [255:0] t;
    if (rst_n) begin
      sz = exp_q8.size();
      n_tests++;
      if (if8.count_o !== 2'(sz)) begin
        n_fail++; $display("FAIL mon8_count: got %0d want %0d", if8.count_o, sz);
      end
      n_tests++;
      if (if8.in_ready_o !== ((sz < 3) && !if8.flush_i)) begin
        n_fail++; $display("FAIL mon8_in_ready: got %b want %b", if8.in_ready_o, (sz < 3) && !if8.flush_i);
      end
      n_tests++;
      if (sz > 0) begin
        if ({if8.inv_o, if8.state_o} !== exp_q8[0]) begin
          n_fail++; $display("FAIL mon8_head: got %h want %h", {if8.inv_o, if8.state_o}, exp_q8[0]);
        end
      end else if ({if8.out_valid_o, if8.inv_o, if8.state_o} !== 258'd0) begin
        n_fail++; $display("FAIL mon8_idle_zero: got %b/%h want 0", if8.out_valid_o, if8.state_o);
      end
      n_tests++;
      if (if8.done_cnt_o !== done8) begin
        n_fail++; $display("FAIL mon8_done_cnt: got %h want %h", if8.done_cnt_o, done8);
      end
      if (if8.flush_i) exp_q8.delete();
      else begin
        if (sz > 0 && if8.out_ready_i) begin
          void'(exp_q8.pop_front());
          done8 = done8 + 16'd1;
        end
        if (if8.in_valid_i && sz < 3) begin
          t = ref_shift(8, if8.inv_i, if8.state_i);
          exp_q8.push_back({if8.inv_i, t});
        end
      end
    end
  end

  task automatic drain_all();
    bit ok;
    if4.in_valid_i = 1'b0; if8.in_valid_i = 1'b0;
    if4.flush_i = 1'b0;    if8.flush_i = 1'b0;
    if4.out_ready_i = 1'b1; if8.out_ready_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if4.count_o == 0 && if8.count_o == 0) begin ok = 1'b1; break; end
    end
    if4.out_ready_i = 1'b0; if8.out_ready_i = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL drain_timeout: got counts %0d/%0d want 0/0", if4.count_o, if8.count_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if ({if4.out_valid_o, if4.in_ready_o, if4.count_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {if4.out_valid_o, if4.in_ready_o, if4.count_o});
    end
    n_tests++;
    if ({if4.inv_o, if4.state_o} !== 129'd0 || if4.done_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", if4.state_o, if4.done_cnt_o);
    end
    n_tests++;
    if (if8.in_ready_o !== 1'b0 || if8.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_nb8: got %b%b want 00", if8.in_ready_o, if8.out_valid_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] s [3];
    logic [255:0] t;
    bit taken;
    for (int i = 0; i < 3; i++) s[i] = {$urandom, $urandom, $urandom, $urandom};
    if4.out_ready_i = 1'b0;
    if4.inv_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if4.in_valid_i = 1'b1; if4.state_i = s[i];
      tick();
    end
    n_tests++;
    if (if4.count_o !== 2'd2 || if4.in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got count %0d ready %b want 2 0", if4.count_o, if4.in_ready_o);
    end
    t = ref_shift(4, 1'b0, {128'd0, s[0]});
    n_tests++;
    if (if4.state_o !== t[127:0]) begin
      n_fail++; $display("FAIL bp_head: got %h want %h", if4.state_o, t[127:0]);
    end
    if4.out_ready_i = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if4.in_ready_o) begin tick(); taken = 1'b1; break; end
      tick();
    end
    if4.in_valid_i = 1'b0;
    n_tests++;
    if (!taken) begin n_fail++; $display("FAIL bp_third_accept: got 0 want 1"); end
    drain_all();
    n_tests++;
    if (if4.done_cnt_o !== 16'd3) begin
      n_fail++; $display("FAIL bp_done_cnt: got %0d want 3", if4.done_cnt_o);
    end
  endtask

  task automatic test_vectors();
    if4.out_ready_i = 1'b0;
    if4.in_valid_i = 1'b1; if4.inv_i = 1'b0; if4.state_i = V_PLAIN;
    tick();
    if4.in_valid_i = 1'b0;
    n_tests++;
    if ({if4.out_valid_o, if4.inv_o, if4.state_o} !== {1'b1, 1'b0, V_SHIFT}) begin
      n_fail++; $display("FAIL vec_forward: got %b %b %h want 1 0 %h", if4.out_valid_o, if4.inv_o, if4.state_o, V_SHIFT);
    end
    if4.out_ready_i = 1'b1;
    if4.in_valid_i = 1'b1; if4.inv_i = 1'b1; if4.state_i = V_SHIFT;
    tick();
    if4.in_valid_i = 1'b0; if4.out_ready_i = 1'b0;
    n_tests++;
    if ({if4.out_valid_o, if4.inv_o, if4.state_o} !== {1'b1, 1'b1, V_PLAIN}) begin
      n_fail++; $display("FAIL vec_inverse: got %b %b %h want 1 1 %h", if4.out_valid_o, if4.inv_o, if4.state_o, V_PLAIN);
    end
    drain_all();
  endtask

  task automatic test_nb8();
    logic [255:0] s8;
    logic [255:0] fwd;
    for (int i = 0; i < 32; i++) s8[255-8*i -: 8] = 8'(i);
    if8.out_ready_i = 1'b0;
    if8.in_valid_i = 1'b1; if8.inv_i = 1'b0; if8.state_i = s8;
    tick();
    if8.in_valid_i = 1'b0;
    n_tests++;
    if (if8.out_valid_o !== 1'b1 || if8.state_o[255:224] !== 32'h00050e13) begin
      n_fail++; $display("FAIL nb8_col0: got %b %h want 1 00050e13", if8.out_valid_o, if8.state_o[255:224]);
    end
    fwd = if8.state_o;
    if8.out_ready_i = 1'b1;
    if8.in_valid_i = 1'b1; if8.inv_i = 1'b1; if8.state_i = fwd;
    tick();
    if8.in_valid_i = 1'b0; if8.out_ready_i = 1'b0;
    n_tests++;
    if (if8.state_o !== s8 || if8.inv_o !== 1'b1) begin
      n_fail++; $display("FAIL nb8_round_trip: got %h want %h", if8.state_o, s8);
    end
    drain_all();
  endtask

  task automatic test_flush();
    if4.out_ready_i = 1'b0; if4.inv_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if4.in_valid_i = 1'b1; if4.state_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    if4.flush_i = 1'b1; if4.in_valid_i = 1'b1; if4.out_ready_i = 1'b1;
    n_tests++;
    if (if4.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got 1 want 0"); end
    tick();
    if4.flush_i = 1'b0; if4.in_valid_i = 1'b0; if4.out_ready_i = 1'b0;
    n_tests++;
    if (if4.count_o !== 2'd0 || if4.out_valid_o !== 1'b0 || if4.state_o !== 128'd0) begin
      n_fail++; $display("FAIL flush_empty: got count %0d valid %b want 0 0", if4.count_o, if4.out_valid_o);
    end
    n_tests++;
    if (if4.done_cnt_o !== 16'd5) begin
      n_fail++; $display("FAIL flush_done_kept: got %0d want 5", if4.done_cnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if4.in_valid_i  = 1'($urandom_range(0, 1));
      if4.out_ready_i = 1'($urandom_range(0, 1));
      if4.inv_i       = 1'($urandom_range(0, 1));
      if4.state_i     = {$urandom, $urandom, $urandom, $urandom};
      if4.flush_i     = ($urandom_range(0, 39) == 0);
      if8.in_valid_i  = 1'($urandom_range(0, 1));
      if8.out_ready_i = 1'($urandom_range(0, 1));
      if8.inv_i       = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) if8.state_i[32*k +: 32] = $urandom;
      if8.flush_i     = ($urandom_range(0, 39) == 0);
      tick();
    end
    drain_all();
  endtask

  task automatic test_async_reset();
    if4.out_ready_i = 1'b0; if4.inv_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if4.in_valid_i = 1'b1; if4.state_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    if4.in_valid_i = 1'b0;
    n_tests++;
    if (if4.count_o !== 2'd2) begin n_fail++; $display("FAIL ar_prefill: got %0d want 2", if4.count_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if4.out_valid_o, if4.count_o, if4.inv_o, if4.state_o, if4.done_cnt_o} !== 148'd0) begin
      n_fail++; $display("FAIL ar_clear: got %b %0d %h %h want all 0", if4.out_valid_o, if4.count_o, if4.state_o, if4.done_cnt_o);
    end
    n_tests++;
    if (if4.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL ar_ready: got 1 want 0"); end
    exp_q4.delete(); exp_q8.delete();
    done4 = 16'd0; done8 = 16'd0;
    tick(); tick();
    rst_n = 1'b1;
    if4.in_valid_i = 1'b1; if4.inv_i = 1'b0; if4.state_i = V_PLAIN;
    tick();
    if4.in_valid_i = 1'b0;
    n_tests++;
    if (if4.state_o !== V_SHIFT || if4.count_o !== 2'd1) begin
      n_fail++; $display("FAIL ar_first_push: got %h want %h", if4.state_o, V_SHIFT);
    end
    drain_all();
  endtask

  task automatic test_done_wrap();
    bit hit;
    hit = 1'b0;
    if4.inv_i = 1'b0;
    if4.in_valid_i = 1'b1; if4.out_ready_i = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if4.state_i = {4{32'(i)}};
      tick();
      if (if4.done_cnt_o == 16'hffff) begin hit = 1'b1; break; end
    end
    if4.in_valid_i = 1'b0; if4.out_ready_i = 1'b0;
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL wrap_reach: got %h want ffff", if4.done_cnt_o); end
    n_tests++;
    if (if4.count_o !== 2'd1) begin n_fail++; $display("FAIL wrap_pending: got %0d want 1", if4.count_o); end
    if4.out_ready_i = 1'b1;
    tick();
    if4.out_ready_i = 1'b0;
    n_tests++;
    if (if4.done_cnt_o !== 16'd0 || if4.count_o !== 2'd0) begin
      n_fail++; $display("FAIL wrap_zero: got %h count %0d want 0 0", if4.done_cnt_o, if4.count_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if4.flush_i = 1'b0; if4.in_valid_i = 1'b0; if4.inv_i = 1'b0; if4.state_i = '0; if4.out_ready_i = 1'b0;
    if8.flush_i = 1'b0; if8.in_valid_i = 1'b0; if8.inv_i = 1'b0; if8.state_i = '0; if8.out_ready_i = 1'b0;
    test_reset();
    test_backpressure();
    test_vectors();
    test_nb8();
    test_flush();
    test_random();
    test_async_reset();
    test_done_wrap();
    tick();
    n_tests++;
    if (exp_q4.size() != 0 || exp_q8.size() != 0) begin
      n_fail++; $display("FAIL final_queues: got %0d/%0d want 0/0", exp_q4.size(), exp_q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
